cpu_sram_arbiter: RTL

- Shares one single-port, 1-cycle-latency synchronous SRAM between the CPU instruction-fetch port and the data load/store port.
- Both CPU ports use a req / addr_ok / data_ok handshake.
- Data port has priority, with a starvation guard for instruction fetch.
- At most one access issues per cycle; responses are in order and pipelined, so sustained throughput is 1 access/cycle.

---
 rtl/cpu_sram_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/cpu_sram_arbiter.sv
// CPU instruction/data port arbiter in front of a single-port, 1-cycle-latency SRAM.
// Data accesses win by default; a 4-bit streak counter forces an instruction grant
// after MAX_DATA_STREAK consecutive data grants while a fetch is waiting.
// Responses return exactly one cycle after the grant and are steered back to the
// port that won the grant.
module cpu_sram_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam logic [3:0] StreakMax = 4'(MAX_DATA_STREAK);

  logic       force_inst;
  logic       grant_data;
  logic       grant_inst;
  logic [3:0] streak_q;
  logic       resp_valid_q;
  logic       resp_owner_q;  // 0 = inst, 1 = data
  logic       resp_wr_q;     // data response belongs to a store

  // Grant decision; everything is masked while reset is held.
  always_comb begin
    force_inst = inst_req && (streak_q == StreakMax);
    grant_data = resetn && data_req && !force_inst;
    grant_inst = resetn && inst_req && !grant_data;
  end

  // Drive the SRAM from the winner and acknowledge it in the same cycle.
  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    sram_en      = grant_data || grant_inst;
    sram_we      = (grant_data && data_wr) ? data_wstrb : {StrbW{1'b0}};
    sram_wdata   = resetn ? data_wdata : {DATA_W{1'b0}};
    if (grant_data) begin
      sram_addr = data_addr;
    end else if (grant_inst) begin
      sram_addr = inst_addr;
    end else begin
      sram_addr = {ADDR_W{1'b0}};
    end
  end

  // Steer the SRAM read data to the owner of the response in flight.
  always_comb begin
    inst_data_ok = resp_valid_q && !resp_owner_q;
    data_data_ok = resp_valid_q && resp_owner_q;
    inst_rdata   = inst_data_ok ? sram_rdata : {DATA_W{1'b0}};
    data_rdata   = (data_data_ok && !resp_wr_q) ? sram_rdata : {DATA_W{1'b0}};
  end

  // Response tag pipeline and data-streak counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_wr_q    <= 1'b0;
      streak_q     <= 4'd0;
    end else begin
      resp_valid_q <= grant_data || grant_inst;
      resp_owner_q <= grant_data;
      resp_wr_q    <= grant_data && data_wr;
      if (!inst_req || grant_inst) begin
        streak_q <= 4'd0;
      end else if (grant_data && (streak_q < StreakMax)) begin
        streak_q <= streak_q + 4'd1;
      end
    end
  end

endmodule
